// File: rtl/split_target_port_pn_if.sv
// split_target_port_pn_if: serial bus, target and arbiter signals
// of one target-side port, with DUT (slave) and driver (master) views.
interface split_target_port_pn_if #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic              bus_data_in;
  logic              bus_data_in_valid;
  logic              bus_mode;
  logic              bus_rw;
  logic              decoder_valid;
  logic [ADDR_W-1:0] target_addr_in;
  logic              target_addr_in_valid;
  logic [DATA_W-1:0] target_data_in;
  logic              target_data_in_valid;
  logic              target_rw;
  logic [DATA_W-1:0] target_data_out;
  logic              target_data_out_valid;
  logic              target_data_out_ready;
  logic              target_split_req;
  logic              arbiter_split_req;
  logic              arbiter_grant;
  logic              bus_split_ack;
  logic              bus_data_out;
  logic              bus_data_out_valid;
  logic [CW-1:0]     fifo_count;
  logic              overflow_err;

  modport slave (
    input  bus_data_in,
    input  bus_data_in_valid,
    input  bus_mode,
    input  bus_rw,
    input  decoder_valid,
    output target_addr_in,
    output target_addr_in_valid,
    output target_data_in,
    output target_data_in_valid,
    output target_rw,
    input  target_data_out,
    input  target_data_out_valid,
    output target_data_out_ready,
    input  target_split_req,
    output arbiter_split_req,
    input  arbiter_grant,
    output bus_split_ack,
    output bus_data_out,
    output bus_data_out_valid,
    output fifo_count,
    output overflow_err
  );

  modport master (
    output bus_data_in,
    output bus_data_in_valid,
    output bus_mode,
    output bus_rw,
    output decoder_valid,
    input  target_addr_in,
    input  target_addr_in_valid,
    input  target_data_in,
    input  target_data_in_valid,
    input  target_rw,
    output target_data_out,
    output target_data_out_valid,
    input  target_data_out_ready,
    output target_split_req,
    input  arbiter_split_req,
    output arbiter_grant,
    input  bus_split_ack,
    input  bus_data_out,
    input  bus_data_out_valid,
    input  fifo_count,
    input  overflow_err
  );
endinterface

// File: rtl/split_target_port_pn.sv
// split_target_port_pn: LSB-first RX deserialiser, read-response FIFO
// and TX serialiser with immediate or split (request/grant) return.
module split_target_port_pn #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  split_target_port_pn_if.slave bif
);
  localparam int MAXW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int BW   = $clog2(MAXW + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  localparam logic [BW-1:0] A_LAST = BW'(ADDR_W - 1);
  localparam logic [BW-1:0] D_LAST = BW'(DATA_W - 1);
  localparam logic [CW-1:0] F_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    RX_ADDR, RX_DATA, WAIT_DEC, DELIVER
  } rx_st_t;

  typedef enum logic [1:0] {
    TX_IDLE, SPLIT_WAIT, TX_SHIFT
  } tx_st_t;

  rx_st_t r_rx_st, w_rx_nx;
  tx_st_t r_tx_st, w_tx_nx;

  logic [BW-1:0]     r_rcnt, w_rcnt_nx;
  logic [ADDR_W-1:0] r_addr, w_addr_nx;
  logic [DATA_W-1:0] r_data, w_data_nx;
  logic              r_rw, w_rw_nx;

  logic              w_bit_ok;
  logic              w_abit;
  logic              w_dbit;
  logic              w_fire;
  logic [BW-1:0]     w_acnt;
  logic [ADDR_W-1:0] w_abase;
  logic [DATA_W-1:0] w_dbase;

  logic [ADDR_W-1:0] r_taddr;
  logic [DATA_W-1:0] r_tdata;
  logic              r_trw;
  logic              r_tav;
  logic              r_tdv;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_fcnt;
  logic              r_ovf;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  logic [DATA_W-1:0] r_shift;
  logic [BW-1:0]     r_tcnt;
  logic              r_req;
  logic              r_ack;

  // half-duplex: the line is ours while shifting a response out
  assign w_bit_ok = bif.bus_data_in_valid && (r_tx_st != TX_SHIFT);

  assign w_abit = w_bit_ok && !bif.bus_mode &&
                  (r_rx_st == RX_ADDR || r_rx_st == RX_DATA);
  assign w_dbit = w_bit_ok && bif.bus_mode &&
                  (r_rx_st == RX_DATA);

  // an address bit seen in RX_DATA restarts capture at bit 0
  assign w_acnt  = (r_rx_st == RX_DATA) ? '0 : r_rcnt;
  assign w_abase = (w_acnt == '0) ? '0 : r_addr;
  assign w_dbase = (r_rcnt == '0) ? '0 : r_data;
  assign w_fire  = (r_rx_st == WAIT_DEC) && bif.decoder_valid;

  always_comb begin
    w_rx_nx   = r_rx_st;
    w_rcnt_nx = r_rcnt;
    w_addr_nx = r_addr;
    w_data_nx = r_data;
    w_rw_nx   = r_rw;
    unique case (r_rx_st)
      RX_ADDR, RX_DATA: begin
        if (w_abit) begin
          w_addr_nx = w_abase |
                      (ADDR_W'(bif.bus_data_in) << w_acnt);
          if (w_acnt == A_LAST) begin
            w_rw_nx   = bif.bus_rw;
            w_rcnt_nx = '0;
            w_data_nx = '0;
            w_rx_nx   = bif.bus_rw ? RX_DATA : WAIT_DEC;
          end else begin
            w_rcnt_nx = w_acnt + 1'b1;
            w_rx_nx   = RX_ADDR;
          end
        end else if (w_dbit) begin
          w_data_nx = w_dbase |
                      (DATA_W'(bif.bus_data_in) << r_rcnt);
          if (r_rcnt == D_LAST) begin
            w_rcnt_nx = '0;
            w_rx_nx   = WAIT_DEC;
          end else begin
            w_rcnt_nx = r_rcnt + 1'b1;
          end
        end
      end
      WAIT_DEC: begin
        if (bif.decoder_valid) begin
          w_rx_nx = DELIVER;
        end else if (!bif.bus_data_in_valid &&
                     !bif.bus_mode) begin
          w_rx_nx   = RX_ADDR;
          w_rcnt_nx = '0;
          w_addr_nx = '0;
          w_data_nx = '0;
        end
      end
      DELIVER: w_rx_nx = RX_ADDR;
      default: w_rx_nx = RX_ADDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_st <= RX_ADDR;
      r_rcnt  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_rw    <= 1'b0;
      r_taddr <= '0;
      r_tdata <= '0;
      r_trw   <= 1'b0;
      r_tav   <= 1'b0;
      r_tdv   <= 1'b0;
    end else begin
      r_rx_st <= w_rx_nx;
      r_rcnt  <= w_rcnt_nx;
      r_addr  <= w_addr_nx;
      r_data  <= w_data_nx;
      r_rw    <= w_rw_nx;
      r_tav   <= w_fire;
      r_tdv   <= w_fire && r_rw;
      if (w_fire) begin
        r_taddr <= r_addr;
        r_tdata <= r_rw ? r_data : '0;
        r_trw   <= r_rw;
      end
    end
  end

  assign w_full  = (r_fcnt == F_FULL);
  assign w_empty = (r_fcnt == '0);
  assign w_push  = bif.target_data_out_valid && !w_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop) begin
        r_fcnt <= r_fcnt + 1'b1;
      end else if (w_pop && !w_push) begin
        r_fcnt <= r_fcnt - 1'b1;
      end
      // fullness is judged before any same-cycle pop
      if (bif.target_data_out_valid && w_full) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= bif.target_data_out;
  end

  always_comb begin
    w_tx_nx = r_tx_st;
    w_pop   = 1'b0;
    unique case (r_tx_st)
      TX_IDLE: begin
        if (!w_empty) begin
          if (bif.target_split_req) begin
            w_tx_nx = SPLIT_WAIT;
          end else begin
            w_pop   = 1'b1;
            w_tx_nx = TX_SHIFT;
          end
        end
      end
      SPLIT_WAIT: begin
        if (bif.arbiter_grant) begin
          w_pop   = 1'b1;
          w_tx_nx = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (r_tcnt == D_LAST) w_tx_nx = TX_IDLE;
      end
      default: w_tx_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_st <= TX_IDLE;
      r_shift <= '0;
      r_tcnt  <= '0;
      r_req   <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_tx_st <= w_tx_nx;
      r_req   <= (w_tx_nx == SPLIT_WAIT);
      r_ack   <= (r_tx_st == SPLIT_WAIT) && bif.arbiter_grant;
      if (w_pop) begin
        r_shift <= r_mem[r_rp];
        r_tcnt  <= '0;
      end else if (r_tx_st == TX_SHIFT) begin
        r_shift <= r_shift >> 1;
        r_tcnt  <= r_tcnt + 1'b1;
      end
    end
  end

  assign bif.target_addr_in        = r_taddr;
  assign bif.target_addr_in_valid  = r_tav;
  assign bif.target_data_in        = r_tdata;
  assign bif.target_data_in_valid  = r_tdv;
  assign bif.target_rw             = r_trw;
  assign bif.target_data_out_ready = !w_full;
  assign bif.arbiter_split_req     = r_req;
  assign bif.bus_split_ack         = r_ack;
  assign bif.bus_data_out_valid    = (r_tx_st == TX_SHIFT);
  assign bif.bus_data_out          = (r_tx_st == TX_SHIFT) &&
                                     r_shift[0];
  assign bif.fifo_count            = r_fcnt;
  assign bif.overflow_err          = r_ovf;
endmodule

// File: tb/tb_split_target_port_pn.sv
// tb_split_target_port_pn: random and directed checks of the target
// port against a transaction-level model of deliveries and responses.
module tb_split_target_port_pn;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int FD = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          rw;
    logic          dv;
  } del_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  del_t          del_q[$];
  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_word = '0;
  int            m_bits = 0;
  bit            m_gap = 1'b0;
  int            n_ack = 0;
  int            first_cyc = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  split_target_port_pn_if #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)
  ) bif ();

  split_target_port_pn #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bif  (bif)
  );

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // bus-side observer: deliveries, serial words, acks
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_bits = 0;
      m_gap  = 1'b0;
    end else begin
      if (m_gap) begin
        chk("tx_gap", 64'(bif.bus_data_out_valid), 64'd0);
        m_gap = 1'b0;
      end else if (bif.bus_data_out_valid) begin
        if (m_bits == 0 && first_cyc < 0) first_cyc = cyc;
        m_word[m_bits] = bif.bus_data_out;
        m_bits++;
        if (m_bits == DW) begin
          tx_q.push_back(m_word);
          m_bits = 0;
          m_gap  = 1'b1;
        end
      end
      if (bif.target_addr_in_valid)
        del_q.push_back('{a: bif.target_addr_in,
                          d: bif.target_data_in,
                          rw: bif.target_rw,
                          dv: bif.target_data_in_valid});
      if (bif.bus_split_ack) n_ack++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(bit b, bit mode, bit rw);
    bif.bus_data_in       = b;
    bif.bus_mode          = mode;
    bif.bus_rw            = rw;
    bif.bus_data_in_valid = 1'b1;
    tick();
    bif.bus_data_in_valid = 1'b0;
    bif.bus_mode          = 1'b0;
  endtask

  task automatic send_addr(logic [AW-1:0] a, bit rw, bit noise);
    for (int i = 0; i < AW; i++) begin
      if (noise && i > 0 && $urandom_range(3) == 0)
        send_bit(1'($urandom_range(1)), 1'b1, 1'b0);
      if (noise && $urandom_range(3) == 0) tick();
      send_bit(a[i], 1'b0, rw);
    end
  endtask

  task automatic send_data(logic [DW-1:0] d, bit noise);
    for (int i = 0; i < DW; i++) begin
      if (noise && $urandom_range(3) == 0) tick();
      send_bit(d[i], 1'b1, 1'b0);
    end
  endtask

  task automatic xfer(logic [AW-1:0] a, bit rw, logic [DW-1:0] d,
                      bit sel, bit noise);
    send_addr(a, rw, noise);
    if (rw) send_data(d, noise);
    bif.decoder_valid = sel;
    tick();
    bif.decoder_valid = 1'b0;
    tick();
  endtask

  task automatic expect_del(string tag, bit present,
                            logic [AW-1:0] a, logic [DW-1:0] d,
                            bit rw);
    del_t e;
    tick();
    chk({tag, "_npulse"}, 64'(del_q.size()), present ? 64'd1 : 64'd0);
    if (present && del_q.size() > 0) begin
      e = del_q.pop_front();
      chk({tag, "_addr"}, 64'(e.a), 64'(a));
      chk({tag, "_data"}, 64'(e.d), rw ? 64'(d) : 64'd0);
      chk({tag, "_rw"}, 64'(e.rw), 64'(rw));
      chk({tag, "_dv"}, 64'(e.dv), 64'(rw));
    end
    del_q.delete();
  endtask

  task automatic push(logic [DW-1:0] w);
    bif.target_data_out       = w;
    bif.target_data_out_valid = 1'b1;
    tick();
    bif.target_data_out_valid = 1'b0;
  endtask

  // grants each split request after a random delay
  task automatic drain(int n, int maxgd, string tag);
    int gd;
    int lim;
    gd  = $urandom_range(maxgd);
    lim = 0;
    while (tx_q.size() < n && lim < 400) begin
      if (bif.arbiter_split_req && !bif.arbiter_grant) begin
        if (gd == 0) begin
          bif.arbiter_grant = 1'b1;
          gd = $urandom_range(maxgd);
        end else begin
          gd--;
        end
      end else begin
        bif.arbiter_grant = 1'b0;
      end
      tick();
      lim++;
    end
    bif.arbiter_grant = 1'b0;
    tick();
    chk({tag, "_nwords"}, 64'(tx_q.size()), 64'(n));
  endtask

  task automatic cmp_words(string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < tx_q.size())
        chk({tag, "_word"}, 64'(tx_q[i]), 64'(exp_q[i]));
    end
    tx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] w;
    bit            rw;
    bit            sel;
    bit            sp;
    int            k;
    int            n0;
    int            ack0;
    int            lim;

    bif.bus_data_in           = 1'b0;
    bif.bus_data_in_valid     = 1'b0;
    bif.bus_mode              = 1'b0;
    bif.bus_rw                = 1'b0;
    bif.decoder_valid         = 1'b0;
    bif.target_data_out       = '0;
    bif.target_data_out_valid = 1'b0;
    bif.target_split_req      = 1'b0;
    bif.arbiter_grant         = 1'b0;

    #1;
    chk("rst_addr", 64'(bif.target_addr_in), 64'd0);
    chk("rst_av", 64'(bif.target_addr_in_valid), 64'd0);
    chk("rst_dv", 64'(bif.target_data_in_valid), 64'd0);
    chk("rst_req", 64'(bif.arbiter_split_req), 64'd0);
    chk("rst_txv", 64'(bif.bus_data_out_valid), 64'd0);
    chk("rst_cnt", 64'(bif.fifo_count), 64'd0);
    chk("rst_ovf", 64'(bif.overflow_err), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    xfer(16'hA5C3, 1'b1, 8'h5A, 1'b1, 1'b0);
    expect_del("wr", 1'b1, 16'hA5C3, 8'h5A, 1'b1);

    xfer(16'h0012, 1'b0, 8'h00, 1'b1, 1'b0);
    expect_del("rd", 1'b1, 16'h0012, 8'h00, 1'b0);

    xfer(16'h1234, 1'b0, 8'h00, 1'b0, 1'b0);
    expect_del("abort", 1'b0, '0, '0, 1'b0);
    xfer(16'h4321, 1'b1, 8'hC7, 1'b1, 1'b0);
    expect_del("post_abort", 1'b1, 16'h4321, 8'hC7, 1'b1);

    for (int t = 0; t < 24; t++) begin
      a   = AW'($urandom());
      d   = DW'($urandom());
      rw  = 1'($urandom_range(1));
      sel = ($urandom_range(4) != 0);
      if (rw && $urandom_range(2) == 0) begin
        send_addr(a, 1'b1, 1'b1);
        k = $urandom_range(1, DW - 1);
        for (int i = 0; i < k; i++)
          send_bit(1'($urandom_range(1)), 1'b1, 1'b0);
        a  = AW'($urandom());
        d  = DW'($urandom());
        rw = 1'($urandom_range(1));
        xfer(a, rw, d, sel, 1'b0);
      end else begin
        xfer(a, rw, d, sel, 1'b1);
      end
      expect_del("rx_rand", sel, a, d, rw);
    end

    bif.target_split_req = 1'b0;
    tx_q.delete();
    first_cyc = -1;
    push(8'h3C);
    n0 = cyc;
    exp_q.push_back(8'h3C);
    drain(1, 0, "lat");
    chk("lat_first", 64'(first_cyc), 64'(n0 + 1));
    cmp_words("lat");

    bif.target_split_req = 1'b1;
    ack0 = n_ack;
    push(8'h81);
    exp_q.push_back(8'h81);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("split_req_hold", 64'(bif.arbiter_split_req), 64'd1);
      chk("split_no_tx", 64'(bif.bus_data_out_valid), 64'd0);
      tick();
    end
    bif.arbiter_grant = 1'b1;
    tick();
    bif.arbiter_grant = 1'b0;
    chk("split_ack", 64'(bif.bus_split_ack), 64'd1);
    chk("split_req_drop", 64'(bif.arbiter_split_req), 64'd0);
    tick();
    chk("split_ack_1cyc", 64'(bif.bus_split_ack), 64'd0);
    drain(1, 0, "split");
    cmp_words("split");
    chk("split_nack", 64'(n_ack - ack0), 64'd1);

    for (int b = 0; b < 8; b++) begin
      k  = $urandom_range(1, FD);
      sp = 1'($urandom_range(1));
      bif.target_split_req = sp;
      ack0 = n_ack;
      for (int i = 0; i < k; i++) begin
        w = DW'($urandom());
        exp_q.push_back(w);
        push(w);
      end
      drain(k, 4, "tx_rand");
      tick();
      cmp_words("tx_rand");
      chk("tx_rand_nack", 64'(n_ack - ack0), sp ? 64'(k) : 64'd0);
    end
    chk("no_ovf_yet", 64'(bif.overflow_err), 64'd0);

    bif.target_split_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w = DW'(8'h10 * (i + 1) + i);
      if (i < FD) exp_q.push_back(w);
      push(w);
    end
    chk("ovf_cnt", 64'(bif.fifo_count), 64'(FD));
    chk("ovf_ready", 64'(bif.target_data_out_ready), 64'd0);
    chk("ovf_err", 64'(bif.overflow_err), 64'd1);
    drain(FD, 3, "ovf");
    cmp_words("ovf");
    chk("ovf_cnt_empty", 64'(bif.fifo_count), 64'd0);
    chk("ovf_sticky", 64'(bif.overflow_err), 64'd1);

    bif.target_split_req = 1'b0;
    push(8'hE1);
    exp_q.push_back(8'hE1);
    lim = 0;
    while (!bif.bus_data_out_valid && lim < 10) begin
      tick();
      lim++;
    end
    chk("hd_tx_start", 64'(bif.bus_data_out_valid), 64'd1);
    for (int i = 0; i < DW - 2; i++)
      send_bit(1'($urandom_range(1)), 1'b0, 1'b1);
    drain(1, 0, "hd");
    cmp_words("hd");
    xfer(16'h6B2D, 1'b0, 8'h00, 1'b1, 1'b0);
    expect_del("hd_rx", 1'b1, 16'h6B2D, 8'h00, 1'b0);

    push(8'hC6);
    lim = 0;
    while (m_bits < 3 && lim < 20) begin
      tick();
      lim++;
    end
    chk("rst_mid_bits", 64'(m_bits), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_txv", 64'(bif.bus_data_out_valid), 64'd0);
    chk("rst_mid_cnt", 64'(bif.fifo_count), 64'd0);
    chk("rst_mid_ovf", 64'(bif.overflow_err), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (DW + 2) tick();
    chk("rst_mid_nowords", 64'(tx_q.size()), 64'd0);
    xfer(16'h3E9F, 1'b1, 8'hB4, 1'b1, 1'b0);
    expect_del("post_rst", 1'b1, 16'h3E9F, 8'hB4, 1'b1);
    push(8'h5D);
    exp_q.push_back(8'h5D);
    drain(1, 0, "post_rst_tx");
    cmp_words("post_rst_tx");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/split_target_port_pn.md
Name: split_target_port_pN

Overview:
- Parametrised next-generation target-side serial bus port. Deserialises the LSB-first address and write data from the 1-bit bus and delivers them to the target once the address decoder confirms selection.
- Buffers target read responses in a FIFO and serialises them back onto the bus. Supports both immediate return and split return (arbiter request/grant before transmit).
- Sits between the serial bus interconnect/arbiter and one target memory/peripheral.

Parameters:
- ADDR_W, 16, address bits per transaction (1..32)
- DATA_W, 8, data bits per word (1..32)
- FIFO_DEPTH, 4, read-response FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  async reset, active-low
- bus_data_in  in  1  serial bit from bus
- bus_data_in_valid  in  1  bus_data_in qualifier
- bus_mode  in  1  1=data phase, 0=address phase
- bus_rw  in  1  1=write, 0=read; sampled with last address bit
- decoder_valid  in  1  address decoder selects this target
- target_addr_in  out  ADDR_W  delivered address
- target_addr_in_valid  out  1  1-cycle pulse
- target_data_in  out  DATA_W  delivered write data (0 on reads)
- target_data_in_valid  out  1  1-cycle pulse, writes only
- target_rw  out  1  rw of delivered transaction, valid with addr pulse
- target_data_out  in  DATA_W  read response word
- target_data_out_valid  in  1  push request
- target_data_out_ready  out  1  FIFO not full
- target_split_req  in  1  1=return responses via split arbitration
- arbiter_split_req  out  1  request bus for split return
- arbiter_grant  in  1  arbiter grant
- bus_split_ack  out  1  1-cycle pulse on grant acceptance
- bus_data_out  out  1  serial response bit
- bus_data_out_valid  out  1  bus_data_out qualifier
- fifo_count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
- overflow_err  out  1  sticky: push dropped while full

Behaviour:
- Reset: all outputs 0; FIFO empty; RX FSM in RX_ADDR with bit counter 0; TX FSM in TX_IDLE; overflow_err cleared only by reset.
- RX FSM, states RX_ADDR, RX_DATA, WAIT_DEC, DELIVER. Bits are accepted only when bus_data_in_valid=1 and the TX FSM is not in TX_SHIFT (half-duplex). Bits arriving during TX_SHIFT are ignored.
- RX_ADDR: accepts bits with bus_mode=0, storing bit k at addr[k]. Bits with bus_mode=1 are ignored. On bit ADDR_W-1, latch bus_rw and clear the counter. Write goes to RX_DATA; read goes to WAIT_DEC.
- RX_DATA: accepts bits with bus_mode=1, storing bit k at data[k]. Bits with bus_mode=0 restart capture: go to RX_ADDR and treat the bit as address bit 0. On bit DATA_W-1, go to WAIT_DEC.
- WAIT_DEC:
  - decoder_valid=1 goes to DELIVER.
  - decoder_valid=0 with bus_data_in_valid=0 and bus_mode=0 aborts: discard buffers and return to RX_ADDR.
  - Otherwise hold.
- DELIVER: for exactly one cycle, assert target_addr_in_valid, set target_rw, and assert target_data_in_valid for writes only. Next state is RX_ADDR. Registered outputs: the pulse appears the cycle after decoder_valid is sampled.
- FIFO:
  - Push when target_data_out_valid=1 and fifo_count<FIFO_DEPTH, evaluated before any same-cycle pop.
  - A push while full is dropped and sets overflow_err, even if a pop occurs in the same cycle.
  - target_data_out_ready = (fifo_count<FIFO_DEPTH).
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM, states TX_IDLE, SPLIT_WAIT, TX_SHIFT:
  - TX_IDLE, FIFO non-empty:
    - target_split_req=0: pop the head into the shift register and go to TX_SHIFT.
    - target_split_req=1: go to SPLIT_WAIT.
  - SPLIT_WAIT: arbiter_split_req=1 (registered). On arbiter_grant=1: pulse bus_split_ack for one cycle, pop the head, go to TX_SHIFT, and drop arbiter_split_req.
  - TX_SHIFT: for DATA_W consecutive cycles, drive bus_data_out=shift[0] with bus_data_out_valid=1, shifting right each cycle. After the last bit, go to TX_IDLE.
  - Consecutive words have a minimum gap of one cycle with bus_data_out_valid=0. Each word in split mode requests its own grant.
- Latency, non-split: push at edge N, pop at N+1, bits valid in cycles N+2 .. N+1+DATA_W.
- Async reset mid-transaction discards partial RX, FIFO contents and any TX in progress. Outputs go to 0 immediately.

Test Plan:
- Write, ADDR_W=16, DATA_W=8: send address 0xA5C3 LSB-first with bus_rw=1, then data 0x5A, then decoder_valid=1 -> one-cycle pulse: target_addr_in=0xA5C3, target_data_in=0x5A, target_rw=1, both valids high.
- Read, non-split: address 0x0012 with bus_rw=0 and decoder_valid -> addr pulse only, data_in_valid=0. Push 0x3C at edge N -> bits 0,0,1,1,1,1,0,0 valid in cycles N+2..N+9.
- Split read: target_split_req=1, push 0x81 -> arbiter_split_req rises and holds 10 cycles until arbiter_grant. Then bus_split_ack pulses once and 0x81 is serialised LSB-first.
- Overflow: push 5 words with FIFO_DEPTH=4 while the TX grant is withheld -> fifo_count=4, ready=0, overflow_err=1, the 5th word is dropped. Draining yields the first 4 words in order.
- Abort and half-duplex: address complete, decoder_valid=0 with the bus idle -> no pulses and RX returns to RX_ADDR. Bus bits sent during TX_SHIFT are ignored (verify by the next address captured correctly).
- Reset asserted mid-TX (bit 3 of 8) -> bus_data_out_valid=0 immediately, fifo_count=0. After release, a new transaction behaves normally.
